// File: rtl/pc_sequencer.sv
// Program counter and four-phase instruction sequencer for the cpu15 core.
// A one-hot FSM walks FT -> DC -> EX -> WB. Each phase strobe and HALTED
// come straight from a state flop, so no input reaches an output
// combinationally. The PC is resolved from the latched opcode and target
// at the EX -> WB edge.
module pc_sequencer #(
  parameter int PC_W = 4
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            RUN_EN,
  input  logic [3:0]      OP_CODE,
  input  logic [PC_W-1:0] OP_ADDR,
  input  logic            CMP_FLAG,
  output logic            CLK_FT,
  output logic            CLK_DC,
  output logic            CLK_EX,
  output logic            CLK_WB,
  output logic [PC_W-1:0] P_COUNT,
  output logic            HALTED
);

  localparam logic [3:0] OPC_JMP = 4'b1100;
  localparam logic [3:0] OPC_JE  = 4'b1011;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  // One-hot encoding. The bit positions below are the strobe taps.
  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    FT   = 6'b000010,
    DC   = 6'b000100,
    EX   = 6'b001000,
    WB   = 6'b010000,
    HALT = 6'b100000
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      op_code_q;
  logic [PC_W-1:0] op_addr_q;
  logic [PC_W-1:0] pc_next;

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. RUN_EN only matters in IDLE and when leaving WB.
  // HALT is left only through reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (RUN_EN) state_d = FT;
      FT:      state_d = DC;
      DC:      state_d = EX;
      EX:      state_d = (op_code_q == OPC_HLT) ? HALT : WB;
      WB:      state_d = RUN_EN ? FT : IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Capture the fetched opcode and target at the DC -> EX edge.
  // The fetch output has been stable since FT.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_code_q <= '0;
      op_addr_q <= '0;
    end else if (state_q == DC) begin
      op_code_q <= OP_CODE;
      op_addr_q <= OP_ADDR;
    end
  end

  // Branch resolution. The increment wraps modulo 2^PC_W.
  always_comb begin
    pc_next = P_COUNT + PC_W'(1);
    unique case (op_code_q)
      OPC_JMP: pc_next = op_addr_q;
      OPC_JE:  if (CMP_FLAG) pc_next = op_addr_q;
      default: pc_next = P_COUNT + PC_W'(1);
    endcase
  end

  // PC moves only at the edge entering WB. It is then stable for a full
  // cycle before the next fetch. hlt leaves it untouched.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      P_COUNT <= '0;
    end else if ((state_q == EX) && (op_code_q != OPC_HLT)) begin
      P_COUNT <= pc_next;
    end
  end

  assign CLK_FT = state_q[1];
  assign CLK_DC = state_q[2];
  assign CLK_EX = state_q[3];
  assign CLK_WB = state_q[4];
  assign HALTED = state_q[5];

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed program scenarios plus randomized
// programs and RUN_EN/CMP_FLAG traffic, checked every cycle against an
// instruction-level reference model.
module tb_pc_sequencer;

  logic       CLK;
  logic       RESET_N;
  logic       RUN_EN;
  logic [3:0] OP_CODE;
  logic [3:0] OP_ADDR;
  logic       CMP_FLAG;
  logic       CLK_FT;
  logic       CLK_DC;
  logic       CLK_EX;
  logic       CLK_WB;
  logic [3:0] P_COUNT;
  logic       HALTED;

  pc_sequencer #(.PC_W(4)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .RUN_EN   (RUN_EN),
    .OP_CODE  (OP_CODE),
    .OP_ADDR  (OP_ADDR),
    .CMP_FLAG (CMP_FLAG),
    .CLK_FT   (CLK_FT),
    .CLK_DC   (CLK_DC),
    .CLK_EX   (CLK_EX),
    .CLK_WB   (CLK_WB),
    .P_COUNT  (P_COUNT),
    .HALTED   (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Program ROM seen by the sequencer
  logic [3:0] rom_op   [16];
  logic [3:0] rom_addr [16];

  // Stimulus controls
  bit run_mode;   // 1 = random RUN_EN, 0 = hold run_fix
  bit run_fix;
  bit cmp_mode;   // 1 = random CMP_FLAG, 0 = hold cmp_fix
  bit cmp_fix;

  int checks   = 0;
  int failures = 0;

  // Reference model: instruction-level view of the sequencer
  bit         m_active;   // an instruction is in flight
  bit         m_halted;
  int         m_phase;    // 0 fetch, 1 decode, 2 execute, 3 write-back
  int         m_pc;
  logic [3:0] m_op;
  logic [3:0] m_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_halted = 0;
    m_phase  = 0;
    m_pc     = 0;
    m_op     = 4'h0;
    m_addr   = 4'h0;
  endtask

  // Advance the model across one rising edge, using the inputs at that edge.
  task automatic model_edge();
    if (m_halted) begin
      // absorbing
    end else if (!m_active) begin
      if (RUN_EN) begin
        m_active = 1;
        m_phase  = 0;
      end
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: begin
          m_op    = rom_op[m_pc];
          m_addr  = rom_addr[m_pc];
          m_phase = 2;
        end
        2: begin
          if (m_op == 4'hF) begin
            m_halted = 1;
            m_active = 0;
          end else begin
            if (m_op == 4'hC || (m_op == 4'hB && CMP_FLAG)) m_pc = int'(m_addr);
            else                                            m_pc = (m_pc + 1) % 16;
            m_phase = 3;
          end
        end
        default: begin
          if (RUN_EN) m_phase = 0;
          else        m_active = 0;
        end
      endcase
    end
  endtask

  task automatic compare();
    logic [3:0] exp_strobes;
    exp_strobes = m_active ? (4'b1000 >> m_phase) : 4'b0000;
    check("strobes", 32'({CLK_FT, CLK_DC, CLK_EX, CLK_WB}), 32'(exp_strobes));
    check("pc", 32'(P_COUNT), 32'(m_pc));
    check("halted", 32'(HALTED), 32'(m_halted));
  endtask

  // New inputs after each falling edge. CMP_FLAG is held through EX, and
  // the ROM output follows the PC.
  task automatic drive();
    if (run_mode) RUN_EN = ($urandom_range(0, 9) < 8);
    else          RUN_EN = run_fix;
    if (!(m_active && m_phase == 2))
      CMP_FLAG = cmp_mode ? 1'($urandom_range(0, 1)) : cmp_fix;
    OP_CODE = rom_op[P_COUNT];
    OP_ADDR = rom_addr[P_COUNT];
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare();
    drive();
  endtask

  // Asynchronous reset, checked before any clock edge can occur
  task automatic do_reset();
    #2 RESET_N = 1'b0;
    #1;
    check("rst_strobes", 32'({CLK_FT, CLK_DC, CLK_EX, CLK_WB}), 32'd0);
    check("rst_pc", 32'(P_COUNT), 32'd0);
    check("rst_halted", 32'(HALTED), 32'd0);
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    drive();
  endtask

  task automatic wait_state(input int ph, input int pc, input int budget);
    int n = 0;
    while (!(m_active && m_phase == ph && m_pc == pc) && n < budget) begin
      tick();
      n++;
    end
    check("reach_state", 32'(m_active && m_phase == ph && m_pc == pc), 32'd1);
  endtask

  task automatic rom_nops();
    for (int i = 0; i < 16; i++) begin
      rom_op[i]   = 4'h0;
      rom_addr[i] = 4'(i ^ 5);
    end
  endtask

  initial begin
    RESET_N  = 1'b1;
    RUN_EN   = 1'b0;
    CMP_FLAG = 1'b0;
    OP_CODE  = 4'h0;
    OP_ADDR  = 4'h0;
    run_mode = 0; run_fix = 1;
    cmp_mode = 0; cmp_fix = 0;
    rom_nops();
    model_reset();

    // Sequential flow with wrap 15 -> 0
    do_reset();
    repeat (60) tick();
    check("seq_pc15", 32'(P_COUNT), 32'd15);
    repeat (4) tick();
    check("wrap_pc", 32'(P_COUNT), 32'd0);
    check("wrap_wb", 32'(CLK_WB), 32'd1);

    // jmp at 13 -> 8
    rom_nops();
    rom_op[13] = 4'b1100; rom_addr[13] = 4'h8;
    do_reset();
    wait_state(2, 13, 200);
    tick();
    check("jmp_pc", 32'(P_COUNT), 32'd8);
    tick();
    check("jmp_ft", 32'(CLK_FT), 32'd1);
    check("jmp_ft_pc", 32'(P_COUNT), 32'd8);

    // je at 12, not taken then taken
    rom_nops();
    rom_op[12] = 4'b1011; rom_addr[12] = 4'hE;
    for (int t = 0; t < 2; t++) begin
      cmp_fix = bit'(t);
      do_reset();
      wait_state(2, 12, 200);
      tick();
      check("je_pc", 32'(P_COUNT), (t == 0) ? 32'd13 : 32'd14);
    end
    cmp_fix = 0;

    // hlt at 14, RUN_EN toggling, then reset
    rom_nops();
    rom_op[14] = 4'b1111;
    do_reset();
    wait_state(2, 14, 200);
    tick();
    check("hlt_halted", 32'(HALTED), 32'd1);
    check("hlt_pc", 32'(P_COUNT), 32'd14);
    run_mode = 1;
    repeat (20) tick();
    run_mode = 0;
    check("hlt_stays", 32'({HALTED, CLK_FT, CLK_DC, CLK_EX, CLK_WB}), 32'b10000);
    do_reset();

    // Pause during DC at 5, resume later
    rom_nops();
    do_reset();
    wait_state(1, 5, 200);
    run_fix = 0; RUN_EN = 1'b0;
    tick();
    tick();
    check("pause_wb", 32'(CLK_WB), 32'd1);
    check("pause_pc", 32'(P_COUNT), 32'd6);
    repeat (4) tick();
    check("pause_idle", 32'({CLK_FT, CLK_DC, CLK_EX, CLK_WB}), 32'd0);
    run_fix = 1; RUN_EN = 1'b1;
    tick();
    check("resume_ft", 32'(CLK_FT), 32'd1);
    check("resume_pc", 32'(P_COUNT), 32'd6);

    // Reset in the middle of EX at 9
    wait_state(2, 9, 200);
    do_reset();
    tick();
    check("restart_ft", 32'(CLK_FT), 32'd1);
    check("restart_pc", 32'(P_COUNT), 32'd0);

    // Random programs with random RUN_EN and CMP_FLAG
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        rom_op[i]   = 4'($urandom_range(0, 15));
        rom_addr[i] = 4'($urandom_range(0, 15));
        if (rom_op[i] == 4'hF && $urandom_range(0, 3) != 0) rom_op[i] = 4'h0;
        if ($urandom_range(0, 3) == 0) rom_op[i] = ($urandom_range(0, 1) != 0) ? 4'hC : 4'hB;
      end
      run_mode = 1;
      cmp_mode = 1;
      do_reset();
      repeat (300) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
